writeback_pipe: RTL and testbench
=================================

// Module: writeback_pipe
// PURPOSE
//  Parametrised LC3 writeback stage: selects the result from one of four sources and holds it
//  for one cycle in a pending register. It then commits that result to an internal register
//  file and updates the one-hot NZP condition codes.
//  Two combinational read ports bypass a pending write, so decode sees the newest value.
//  Sits between execute/memory and decode; also reports a retired-write count.
// PARAMETERS
//  DATA_W          16  datapath / register width
//  ADDR_W          3   register index width; NREG = 2**ADDR_W registers
//  CNT_W           8   width of retired-write counter
//  CLEAR_ON_RESET  1   1: reset zeroes every RF entry; 0: RF contents untouched by reset
// PORTS
//  clock             in   1       rising-edge clock
//  reset             in   1       synchronous, active-low reset (0 = reset at next edge)
//  enable_writeback  in   1       accept a write this cycle
//  W_Control         in   2       source select: 0 aluout, 1 memout, 2 pcout, 3 npc
//  aluout,memout     in   DATA_W  result sources
//  pcout,npc         in   DATA_W  result sources
//  dr                in   ADDR_W  destination register
//  sr1, sr2          in   ADDR_W  read addresses
//  d1, d2            out  DATA_W  read data (combinational, bypassed)
//  psr               out  3       NZP one-hot {N,Z,P} of last committed value
//  pend_valid        out  1       pending write present
//  wb_count          out  CNT_W   number of committed writes (wraps)
// BEHAVIOUR
//  Select: DR_in = mux(W_Control); all four codes are defined. There is no latch and no default hold.
//  Accept: on an edge with reset=1 and enable_writeback=1, capture pend_data<=DR_in and pend_dr<=dr,
//   and set pend_valid<=1. If enable_writeback=0, clear pend_valid<=0.
//  Commit: on every edge with reset=1 where pend_valid=1, perform all of the following:
//   RF[pend_dr]<=pend_data; psr<=nzp(pend_data); wb_count<=wb_count+1.
//  Latency: an input sampled at edge E is readable via bypass in cycle E..E+1. It is in the RF,
//   and reflected in psr, after edge E+1.
//  Simultaneous accept and commit on the same edge: the old pending entry commits and the new
//   entry is captured. This gives full throughput of one write per cycle with no stall.
//  nzp(x): x[DATA_W-1]=1 -> 3'b100; x==0 -> 3'b010; else 3'b001. psr is always exactly one-hot.
//  Read: d1 = (pend_valid && sr1==pend_dr) ? pend_data : RF[sr1]; d2 is identical using sr2.
//   The bypass covers back-to-back writes to the same dr: the newest pending value wins.
//  wb_count wraps from 2**CNT_W-1 to 0 without a flag.
//  Reset (reset=0 at an edge) has priority over accept and commit:
//   pend_valid<=0; psr<=3'b010; wb_count<=0; RF cleared iff CLEAR_ON_RESET.
//   A pending write held at reset is discarded (never committed). Inputs are ignored that cycle.
//  Outputs after reset: d1/d2 = 0 when CLEAR_ON_RESET=1; psr=3'b010; pend_valid=0; wb_count=0.
//  No X propagation: pend_data and pend_dr are don't-care while pend_valid=0.
// TESTING
//  1 Reset: hold reset=0 for 2 edges -> psr=010, wb_count=0, pend_valid=0, d1=d2=0 for all sr.
//  2 Source select: write R1 with W_Control=0..3 using aluout=1, memout=2, pcout=3, npc=4
//    -> R1 reads 1,2,3,4 in turn; W_Control=3 must select npc.
//  3 Bypass: write R2=16'h8000, then immediately read sr1=2 -> d1=8000 one cycle after accept,
//    before commit. psr=100 only after the next edge.
//  4 Back-to-back: same-dr writes R3=5 then R3=0 on consecutive cycles -> d1 shows 5 then 0.
//    psr goes 001 then 010; wb_count advances by 2.
//  5 Reset mid-op: accept R4=7, then assert reset=0 on the next edge -> R4 is not written,
//    wb_count=0, psr=010.
//  6 Wrap: CNT_W=2; perform 5 writes -> wb_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/writeback_pipe_if.sv
// Writeback stage bus: result sources and destination from execute/memory,
// read ports toward decode, and status (psr, pending flag, retired count).
interface writeback_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  logic              enable_writeback;
  logic [1:0]        W_Control;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] memout;
  logic [DATA_W-1:0] pcout;
  logic [DATA_W-1:0] npc;
  logic [ADDR_W-1:0] dr;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [2:0]        psr;
  logic              pend_valid;
  logic [CNT_W-1:0]  wb_count;

  // Upstream pipeline / decode side
  modport master (
    output enable_writeback, W_Control, aluout, memout, pcout, npc, dr, sr1, sr2,
    input  d1, d2, psr, pend_valid, wb_count
  );

  // Writeback stage itself
  modport slave (
    input  enable_writeback, W_Control, aluout, memout, pcout, npc, dr, sr1, sr2,
    output d1, d2, psr, pend_valid, wb_count
  );
endinterface

// File: rtl/writeback_pipe.sv
// LC3 writeback stage: selects one of four results, holds it one cycle in a
// pending register, then commits it to the register file and updates NZP.
// Read ports bypass the pending entry so decode always sees the newest value.
module writeback_pipe #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 3,
  parameter int CNT_W          = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clock,
  input logic reset,
  writeback_pipe_if.slave wb
);
  localparam int NREG = 2 ** ADDR_W;

  // One-hot {N,Z,P} classification of a committed value
  function automatic logic [2:0] nzp(input logic signed [DATA_W-1:0] x);
    if (x < 0)       return 3'b100;
    else if (x == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  // Retired-write counter increment; wraps silently
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  logic signed [DATA_W-1:0] dr_in;
  logic signed [DATA_W-1:0] pend_data_p0;
  logic        [ADDR_W-1:0] pend_dr_p0;
  logic                     vld_p0;
  logic signed [DATA_W-1:0] rf [NREG];
  logic        [2:0]        psr_q;
  logic        [CNT_W-1:0]  cnt_q;

  // Result source mux; every select code maps to a source
  always_comb begin
    dr_in = wb.aluout;
    case (wb.W_Control)
      2'd0:    dr_in = wb.aluout;
      2'd1:    dr_in = wb.memout;
      2'd2:    dr_in = wb.pcout;
      default: dr_in = wb.npc;
    endcase
  end

  // ---- Stage p0: pending register (accept) ----
  // Pending-valid follows enable; reset drops any held write
  always_ff @(posedge clock) begin
    if (!reset) vld_p0 <= 1'b0;
    else        vld_p0 <= wb.enable_writeback;
  end

  // Pending data/destination; don't-care while vld_p0 is low
  always_ff @(posedge clock) begin
    if (wb.enable_writeback) begin
      pend_data_p0 <= dr_in;
      pend_dr_p0   <= wb.dr;
    end
  end

  // ---- Stage commit: register file, condition codes, retired count ----
  // Register file write; reset optionally clears every entry
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end
    end else if (vld_p0) begin
      rf[pend_dr_p0] <= pend_data_p0;
    end
  end

  // Condition codes and retired-write counter advance on each commit
  always_ff @(posedge clock) begin
    if (!reset) begin
      psr_q <= 3'b010;
      cnt_q <= '0;
    end else if (vld_p0) begin
      psr_q <= nzp(pend_data_p0);
      cnt_q <= cnt_inc(cnt_q);
    end
  end

  // Bypassed read ports: a matching pending write overrides the RF
  always_comb begin
    wb.d1 = (vld_p0 && wb.sr1 == pend_dr_p0) ? pend_data_p0 : rf[wb.sr1];
    wb.d2 = (vld_p0 && wb.sr2 == pend_dr_p0) ? pend_data_p0 : rf[wb.sr2];
  end

  assign wb.psr        = psr_q;
  assign wb.pend_valid = vld_p0;
  assign wb.wb_count   = cnt_q;
endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe: vector table for source select and NZP,
// hand sequences for bypass, back-to-back writes, reset mid-op and count wrap.
module tb_writeback_pipe;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  writeback_pipe_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) bus ();
  writeback_pipe_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) bus_w ();

  // Second instance with a 2-bit counter mirrors the same stimulus
  assign bus_w.enable_writeback = bus.enable_writeback;
  assign bus_w.W_Control        = bus.W_Control;
  assign bus_w.aluout           = bus.aluout;
  assign bus_w.memout           = bus.memout;
  assign bus_w.pcout            = bus.pcout;
  assign bus_w.npc              = bus.npc;
  assign bus_w.dr               = bus.dr;
  assign bus_w.sr1              = bus.sr1;
  assign bus_w.sr2              = bus.sr2;

  writeback_pipe #(.DATA_W(16), .ADDR_W(3), .CNT_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  writeback_pipe #(.DATA_W(16), .ADDR_W(3), .CNT_W(2), .CLEAR_ON_RESET(1'b1)) dut_w (
    .clock (clock),
    .reset (reset),
    .wb    (bus_w)
  );

  typedef struct {
    logic [1:0]  wc;
    logic [2:0]  dr;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [15:0] pc;
    logic [15:0] np;
    logic [15:0] exp_d;
    logic [2:0]  exp_psr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] wc, input logic [2:0] dr,
                       input logic [15:0] alu, input logic [15:0] mem,
                       input logic [15:0] pc, input logic [15:0] np);
    bus.enable_writeback = en;
    bus.W_Control        = wc;
    bus.dr               = dr;
    bus.aluout           = alu;
    bus.memout           = mem;
    bus.pcout            = pc;
    bus.npc              = np;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    logic [2:0] prev_psr;
    logic [1:0] wrap_exp;

    vecs[0] = '{2'd0, 3'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0001, 3'b001};
    vecs[1] = '{2'd1, 3'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0002, 3'b001};
    vecs[2] = '{2'd2, 3'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0003, 3'b001};
    vecs[3] = '{2'd3, 3'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004, 3'b001};
    vecs[4] = '{2'd0, 3'd2, 16'h8000, 16'h0001, 16'h0002, 16'h0003, 16'h8000, 3'b100};
    vecs[5] = '{2'd1, 3'd5, 16'h0005, 16'h0000, 16'h0006, 16'h0007, 16'h0000, 3'b010};
    vecs[6] = '{2'd3, 3'd6, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 3'b001};
    vecs[7] = '{2'd2, 3'd7, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 3'b100};

    // Reset: two edges with reset low
    reset = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    bus.sr1 = 3'd0;
    bus.sr2 = 3'd0;
    step();
    step();
    reset = 1'b1;
    chk("rst_psr", 32'(bus.psr), 32'h2);
    chk("rst_cnt", 32'(bus.wb_count), 32'h0);
    chk("rst_cnt_w", 32'(bus_w.wb_count), 32'h0);
    chk("rst_pend", 32'(bus.pend_valid), 32'h0);
    for (int r = 0; r < 8; r++) begin
      bus.sr1 = 3'(r);
      bus.sr2 = 3'(7 - r);
      #1;
      chk("rst_d1", 32'(bus.d1), 32'h0);
      chk("rst_d2", 32'(bus.d2), 32'h0);
    end

    // Vector table: accept, check bypass, commit, check RF/psr/count
    exp_cnt  = 8'd0;
    prev_psr = 3'b010;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].wc, vecs[i].dr, vecs[i].alu, vecs[i].mem, vecs[i].pc, vecs[i].np);
      bus.sr1 = vecs[i].dr;
      step();
      bus.enable_writeback = 1'b0;
      #1;
      chk("vec_bypass_d1", 32'(bus.d1), 32'(vecs[i].exp_d));
      chk("vec_pend", 32'(bus.pend_valid), 32'h1);
      chk("vec_psr_before", 32'(bus.psr), 32'(prev_psr));
      step();
      exp_cnt++;
      chk("vec_rf_d1", 32'(bus.d1), 32'(vecs[i].exp_d));
      chk("vec_psr", 32'(bus.psr), 32'(vecs[i].exp_psr));
      chk("vec_cnt", 32'(bus.wb_count), 32'(exp_cnt));
      chk("vec_pend_clr", 32'(bus.pend_valid), 32'h0);
      prev_psr = vecs[i].exp_psr;
    end

    // Non-bypassed reads of final RF contents through d2
    bus.sr2 = 3'd1; #1; chk("rf_r1", 32'(bus.d2), 32'h0004);
    bus.sr2 = 3'd2; #1; chk("rf_r2", 32'(bus.d2), 32'h8000);
    bus.sr2 = 3'd5; #1; chk("rf_r5", 32'(bus.d2), 32'h0000);
    bus.sr2 = 3'd6; #1; chk("rf_r6", 32'(bus.d2), 32'h7FFF);
    bus.sr2 = 3'd7; #1; chk("rf_r7", 32'(bus.d2), 32'hFFFF);
    bus.sr2 = 3'd0; #1; chk("rf_r0", 32'(bus.d2), 32'h0000);

    // Back-to-back writes to R3: 5 then 0
    bus.sr1 = 3'd3;
    bus.sr2 = 3'd3;
    drive(1'b1, 2'd0, 3'd3, 16'h0005, 16'h0, 16'h0, 16'h0);
    step();
    chk("b2b_d1_first", 32'(bus.d1), 32'h0005);
    chk("b2b_d2_first", 32'(bus.d2), 32'h0005);
    drive(1'b1, 2'd1, 3'd3, 16'h1111, 16'h0000, 16'h0, 16'h0);
    step();
    bus.enable_writeback = 1'b0;
    #1;
    chk("b2b_d1_second", 32'(bus.d1), 32'h0000);
    chk("b2b_psr_mid", 32'(bus.psr), 32'h1);
    chk("b2b_cnt_mid", 32'(bus.wb_count), 32'(exp_cnt + 8'd1));
    step();
    exp_cnt = exp_cnt + 8'd2;
    chk("b2b_psr_end", 32'(bus.psr), 32'h2);
    chk("b2b_d1_end", 32'(bus.d1), 32'h0000);
    chk("b2b_cnt_end", 32'(bus.wb_count), 32'(exp_cnt));

    // Reset mid-op: pending R4=7 is discarded
    bus.sr1 = 3'd4;
    bus.sr2 = 3'd1;
    drive(1'b1, 2'd0, 3'd4, 16'h0007, 16'h0, 16'h0, 16'h0);
    step();
    chk("mid_pend", 32'(bus.pend_valid), 32'h1);
    chk("mid_bypass", 32'(bus.d1), 32'h0007);
    reset = 1'b0;
    drive(1'b1, 2'd0, 3'd4, 16'h0009, 16'h0, 16'h0, 16'h0);
    step();
    reset = 1'b1;
    bus.enable_writeback = 1'b0;
    #1;
    chk("mid_pend_clr", 32'(bus.pend_valid), 32'h0);
    chk("mid_cnt", 32'(bus.wb_count), 32'h0);
    chk("mid_psr", 32'(bus.psr), 32'h2);
    chk("mid_r4", 32'(bus.d1), 32'h0000);
    chk("mid_r1_cleared", 32'(bus.d2), 32'h0000);
    step();
    chk("mid_r4_after", 32'(bus.d1), 32'h0000);
    chk("mid_cnt_after", 32'(bus.wb_count), 32'h0);

    // Wrap: five consecutive writes, 2-bit counter goes 1,2,3,0,1
    bus.sr1 = 3'd0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd0, 3'd0, 16'(k + 1), 16'h0, 16'h0, 16'h0);
      step();
      if (k > 0) begin
        wrap_exp = 2'(k);
        chk("wrap_cnt_w", 32'(bus_w.wb_count), 32'(wrap_exp));
        chk("wrap_cnt", 32'(bus.wb_count), 32'(k));
      end
    end
    bus.enable_writeback = 1'b0;
    step();
    chk("wrap_cnt_w_last", 32'(bus_w.wb_count), 32'h1);
    chk("wrap_cnt_last", 32'(bus.wb_count), 32'h5);
    chk("wrap_r0", 32'(bus.d1), 32'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
